// File: rtl/bin_ext_gcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gcd_pkg                                                   |
// | Purpose  : Shared state encoding and coefficient width helper for    |
// |            the binary extended-GCD engine.                           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package gcd_pkg;

   // Engine phases: operand capture, common-2 removal, HAC loop,
   // coefficient normalisation, result publish.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EVEN = 3'd1,
      LOOP = 3'd2,
      NORM = 3'd3,
      DONE = 3'd4
   } state_t;

   // Signed coefficients need three extra bits: one for sign and two of
   // headroom for the (A + y') sum taken before the halving shift.
   function automatic int coef_w(input int nbits);
      return nbits + 3;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bin_ext_gcd_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bin_ext_gcd_step                                          |
// | Purpose  : Combinational datapath for one binary extended-GCD loop   |
// |            iteration (halve u or v, or subtract the smaller one).    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module bin_ext_gcd_step
   import gcd_pkg::*;
#(
   parameter int NBITS = 256,
   localparam int COEF_W = coef_w(NBITS)
) (
   input  logic        [NBITS-1:0]  i_u,
   input  logic        [NBITS-1:0]  i_v,
   input  logic        [NBITS-1:0]  i_xp,
   input  logic        [NBITS-1:0]  i_yp,
   input  logic signed [COEF_W-1:0] i_a,
   input  logic signed [COEF_W-1:0] i_b,
   input  logic signed [COEF_W-1:0] i_c,
   input  logic signed [COEF_W-1:0] i_d,
   output logic        [NBITS-1:0]  o_u,
   output logic        [NBITS-1:0]  o_v,
   output logic signed [COEF_W-1:0] o_a,
   output logic signed [COEF_W-1:0] o_b,
   output logic signed [COEF_W-1:0] o_c,
   output logic signed [COEF_W-1:0] o_d
);

   logic signed [COEF_W-1:0] w_xp_ext;
   logic signed [COEF_W-1:0] w_yp_ext;
   logic signed [COEF_W-1:0] w_a_odd;
   logic signed [COEF_W-1:0] w_b_odd;
   logic signed [COEF_W-1:0] w_c_odd;
   logic signed [COEF_W-1:0] w_d_odd;

   assign w_xp_ext = $signed({3'b000, i_xp});
   assign w_yp_ext = $signed({3'b000, i_yp});

   // Adjusted pairs used when a coefficient pair is not evenly divisible;
   // adding (y', -x') keeps the Bezout relation and makes both even.
   assign w_a_odd = i_a + w_yp_ext;
   assign w_b_odd = i_b - w_xp_ext;
   assign w_c_odd = i_c + w_yp_ext;
   assign w_d_odd = i_d - w_xp_ext;

   // One HAC 14.61 iteration; untouched values pass straight through.
   always_comb begin
      o_u = i_u;
      o_v = i_v;
      o_a = i_a;
      o_b = i_b;
      o_c = i_c;
      o_d = i_d;
      if (!i_u[0]) begin
         o_u = i_u >> 1;
         if (!i_a[0] && !i_b[0]) begin
            o_a = i_a >>> 1;
            o_b = i_b >>> 1;
         end else begin
            o_a = w_a_odd >>> 1;
            o_b = w_b_odd >>> 1;
         end
      end else if (!i_v[0]) begin
         o_v = i_v >> 1;
         if (!i_c[0] && !i_d[0]) begin
            o_c = i_c >>> 1;
            o_d = i_d >>> 1;
         end else begin
            o_c = w_c_odd >>> 1;
            o_d = w_d_odd >>> 1;
         end
      end else if (i_u >= i_v) begin
         o_u = i_u - i_v;
         o_a = i_a - i_c;
         o_b = i_b - i_d;
      end else begin
         o_v = i_v - i_u;
         o_c = i_c - i_a;
         o_d = i_d - i_b;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bin_ext_gcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bin_ext_gcd                                               |
// | Purpose  : Sequential binary extended-GCD / modular-inverse engine.  |
// |            Produces gcd(x,y) and a, b with a*x + b*y = gcd,          |
// |            0 <= a < y' (y with the common power of two removed).     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module bin_ext_gcd
   import gcd_pkg::*;
#(
   parameter int NBITS = 256,
   localparam int COEF_W = coef_w(NBITS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable_p,
   input  logic        [NBITS-1:0]  x,
   input  logic        [NBITS-1:0]  y,
   output logic signed [COEF_W-1:0] a,
   output logic signed [COEF_W-1:0] b,
   output logic        [NBITS-1:0]  gcd,
   output logic                     done_irq_p
);

   localparam int KW = $clog2(NBITS + 1);
   localparam logic signed [COEF_W-1:0] c_ONE = COEF_W'(1);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic        [NBITS-1:0]  r_xp;
   logic        [NBITS-1:0]  r_yp;
   logic        [NBITS-1:0]  r_u;
   logic        [NBITS-1:0]  r_v;
   logic        [KW-1:0]     r_k;
   logic signed [COEF_W-1:0] r_ca;
   logic signed [COEF_W-1:0] r_cb;
   logic signed [COEF_W-1:0] r_cc;
   logic signed [COEF_W-1:0] r_cd;
   logic signed [COEF_W-1:0] r_a;
   logic signed [COEF_W-1:0] r_b;
   logic        [NBITS-1:0]  r_gcd;
   logic                     r_done;

   logic        [NBITS-1:0]  w_u_nxt;
   logic        [NBITS-1:0]  w_v_nxt;
   logic signed [COEF_W-1:0] w_a_nxt;
   logic signed [COEF_W-1:0] w_b_nxt;
   logic signed [COEF_W-1:0] w_c_nxt;
   logic signed [COEF_W-1:0] w_d_nxt;
   logic signed [COEF_W-1:0] w_xp_ext;
   logic signed [COEF_W-1:0] w_yp_ext;
   logic                     w_both_even;
   logic                     w_degen;
   logic                     w_c_neg;
   logic                     w_c_ge;

   bin_ext_gcd_step #(.NBITS(NBITS)) u_step (
      .i_u  (r_u),
      .i_v  (r_v),
      .i_xp (r_xp),
      .i_yp (r_yp),
      .i_a  (r_ca),
      .i_b  (r_cb),
      .i_c  (r_cc),
      .i_d  (r_cd),
      .o_u  (w_u_nxt),
      .o_v  (w_v_nxt),
      .o_a  (w_a_nxt),
      .o_b  (w_b_nxt),
      .o_c  (w_c_nxt),
      .o_d  (w_d_nxt)
   );

   assign w_xp_ext    = $signed({3'b000, r_xp});
   assign w_yp_ext    = $signed({3'b000, r_yp});
   assign w_both_even = ~r_xp[0] & ~r_yp[0];
   assign w_degen     = (x == '0) || (y == '0);
   assign w_c_neg     = r_cc[COEF_W-1];
   assign w_c_ge      = !w_c_neg && (r_cc >= w_yp_ext);

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode; zero operands skip straight to publishing.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (enable_p) w_state_nxt = w_degen ? DONE : EVEN;
         EVEN: if (!w_both_even) w_state_nxt = LOOP;
         LOOP: if (r_u == '0) w_state_nxt = NORM;
         NORM: if (!w_c_neg && !w_c_ge) w_state_nxt = DONE;
         DONE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath registers and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_xp   <= '0;
         r_yp   <= '0;
         r_u    <= '0;
         r_v    <= '0;
         r_k    <= '0;
         r_ca   <= '0;
         r_cb   <= '0;
         r_cc   <= '0;
         r_cd   <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_gcd  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (enable_p) begin
                  r_xp <= x;
                  r_yp <= y;
                  r_k  <= '0;
                  // Preload the degenerate answer; the normal path
                  // overwrites these before they are published.
                  r_v  <= (x == '0) ? y : x;
                  r_cc <= (x != '0 && y == '0) ? c_ONE : '0;
                  r_cd <= (x == '0 && y != '0) ? c_ONE : '0;
               end
            end
            EVEN: begin
               if (w_both_even) begin
                  r_xp <= r_xp >> 1;
                  r_yp <= r_yp >> 1;
                  r_k  <= r_k + KW'(1);
               end else begin
                  r_u  <= r_xp;
                  r_v  <= r_yp;
                  r_ca <= c_ONE;
                  r_cb <= '0;
                  r_cc <= '0;
                  r_cd <= c_ONE;
               end
            end
            LOOP: begin
               if (r_u != '0) begin
                  r_u  <= w_u_nxt;
                  r_v  <= w_v_nxt;
                  r_ca <= w_a_nxt;
                  r_cb <= w_b_nxt;
                  r_cc <= w_c_nxt;
                  r_cd <= w_d_nxt;
               end
            end
            NORM: begin
               if (w_c_neg) begin
                  r_cc <= r_cc + w_yp_ext;
                  r_cd <= r_cd - w_xp_ext;
               end else if (w_c_ge) begin
                  r_cc <= r_cc - w_yp_ext;
                  r_cd <= r_cd + w_xp_ext;
               end
            end
            DONE: begin
               r_gcd  <= r_v << r_k;
               r_a    <= r_cc;
               r_b    <= r_cd;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign a          = r_a;
   assign b          = r_b;
   assign gcd        = r_gcd;
   assign done_irq_p = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bin_ext_gcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bin_ext_gcd                                            |
// | Purpose  : Scoreboard bench for bin_ext_gcd against an arithmetic    |
// |            reference (Euclid gcd, extended-Euclid inverse).          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_bin_ext_gcd;

   localparam int N  = 256;
   localparam int CW = N + 3;
   localparam int WW = 2 * N + 8;

   typedef logic signed [WW-1:0] wide_t;

   typedef struct {
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic [N-1:0] g;
      wide_t        yp;
      bit           deg;
      bit           exact;
      wide_t        ea;
      wide_t        eb;
      int           c0;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 enable_p;
   logic        [N-1:0]  x;
   logic        [N-1:0]  y;
   logic signed [CW-1:0] a;
   logic signed [CW-1:0] b;
   logic        [N-1:0]  gcd;
   logic                 done_irq_p;

   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   exp_t sb[$];

   bin_ext_gcd #(.NBITS(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable_p   (enable_p),
      .x          (x),
      .y          (y),
      .a          (a),
      .b          (b),
      .gcd        (gcd),
      .done_irq_p (done_irq_p)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [N-1:0] ref_gcd(input logic [N-1:0] p, input logic [N-1:0] q);
      logic [N-1:0] t;
      while (q != '0) begin
         t = p % q;
         p = q;
         q = t;
      end
      return p;
   endfunction

   // Modular inverse of xv mod m by the textbook extended Euclid.
   function automatic wide_t inv_mod(input wide_t xv, input wide_t m);
      wide_t r0, r1, s0, s1, q, t;
      r0 = xv; r1 = m; s0 = 1; s1 = 0;
      while (r1 != 0) begin
         q  = r0 / r1;
         t  = r0 - q * r1; r0 = r1; r1 = t;
         t  = s0 - q * s1; s0 = s1; s1 = t;
      end
      s0 = s0 % m;
      if (s0 < 0) s0 = s0 + m;
      return s0;
   endfunction

   function automatic exp_t make_exp(input logic [N-1:0] xi, input logic [N-1:0] yi,
                                     input bit ovr, input wide_t oa, input wide_t ob);
      exp_t  e;
      int    k;
      wide_t xfw, yfw, gw, xw;
      xfw = xi; yfw = yi;
      e.x = xi; e.y = yi; e.c0 = cyc;
      e.deg = (xi == '0) || (yi == '0);
      e.exact = 1'b0; e.ea = 0; e.eb = 0; e.yp = 0;
      if (e.deg) begin
         e.g     = (xi == '0) ? yi : xi;
         e.exact = 1'b1;
         e.ea    = (xi != '0) ? 1 : 0;
         e.eb    = (xi == '0 && yi != '0) ? 1 : 0;
      end else begin
         e.g = ref_gcd(xi, yi);
         k = 0;
         while (!xi[k] && !yi[k]) k++;
         xw   = xi >> k;
         e.yp = yi >> k;
         gw   = e.g;
         if ((e.g >> k) == 1) begin
            e.ea    = inv_mod(xw, e.yp);
            e.eb    = (gw - e.ea * xfw) / yfw;
            e.exact = 1'b1;
         end
      end
      if (ovr) begin
         e.exact = 1'b1; e.ea = oa; e.eb = ob;
      end
      return e;
   endfunction

   function automatic logic [N-1:0] rnd(input int len);
      logic [N-1:0] r, m;
      for (int w = 0; w < N / 32; w++) r[w*32 +: 32] = $urandom;
      m = '1;
      m = m >> (N - len);
      return r & m;
   endfunction

   task automatic issue(input logic [N-1:0] xi, input logic [N-1:0] yi, input bit push,
                        input bit ovr, input wide_t oa, input wide_t ob);
      x = xi; y = yi; enable_p = 1'b1;
      if (push) sb.push_back(make_exp(xi, yi, ovr, oa, ob));
      @(negedge clk);
      enable_p = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 8 * N + 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL timeout: %0d result(s) outstanding after %0d cycles, required 0", sb.size(), n);
         sb.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run(input logic [N-1:0] xi, input logic [N-1:0] yi,
                      input bit ovr, input wide_t oa, input wide_t ob);
      issue(xi, yi, 1'b1, ovr, oa, ob);
      drain();
   endtask

   task automatic check_zero(input string nm);
      checks++;
      if (a !== '0 || b !== '0 || gcd !== '0 || done_irq_p !== 1'b0) begin
         errors++;
         $display("FAIL %s: a=%0d b=%0d gcd=%0d done=%0b, required all 0", nm, a, b, gcd, done_irq_p);
      end
   endtask

   initial begin
      logic [N-1:0] bx, by, t128, xi, yi;
      int           s, f, d0;

      rst = 1'b1; enable_p = 1'b0; x = '0; y = '0;

      // Monitor: compares every done pulse against the oldest expectation.
      fork
         begin : monitor
            exp_t  e;
            wide_t aw, bw, xw, yw, gw;
            forever begin
               @(negedge clk);
               if (done_irq_p === 1'b1) begin
                  done_cnt++;
                  if (sb.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_done: gcd=%0d a=%0d, required no pulse", gcd, a);
                  end else begin
                     e  = sb.pop_front();
                     aw = a; bw = b; gw = gcd; xw = e.x; yw = e.y;
                     checks++;
                     if (gcd !== e.g) begin
                        errors++;
                        $display("FAIL gcd x=%0d y=%0d: got %0d, required %0d", e.x, e.y, gcd, e.g);
                     end
                     if (e.deg) begin
                        checks++;
                        if (cyc - e.c0 != 2) begin
                           errors++;
                           $display("FAIL degenerate_latency: got %0d cycles, required 2", cyc - e.c0);
                        end
                     end else begin
                        checks++;
                        if (aw * xw + bw * yw != gw) begin
                           errors++;
                           $display("FAIL identity x=%0d y=%0d: a*x+b*y=%0d, required %0d", e.x, e.y, aw * xw + bw * yw, gw);
                        end
                        checks++;
                        if (aw < 0 || aw >= e.yp) begin
                           errors++;
                           $display("FAIL a_range: a=%0d, required 0 <= a < %0d", aw, e.yp);
                        end
                     end
                     if (e.exact) begin
                        checks++;
                        if (aw != e.ea || bw != e.eb) begin
                           errors++;
                           $display("FAIL coeffs x=%0d y=%0d: a=%0d b=%0d, required a=%0d b=%0d", e.x, e.y, aw, bw, e.ea, e.eb);
                        end
                     end
                  end
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_zero("reset_state");

      // Directed vectors with known coefficients.
      run(319, 177, 1'b1, 91, -164);
      run(220, 961, 1'b1, 83, -19);
      run(12, 18, 1'b1, 2, -1);
      run(0, 5, 1'b0, 0, 0);
      run(7, 0, 1'b0, 0, 0);
      run(0, 0, 1'b0, 0, 0);

      // Full-width operands, with a second start mid-run that must be ignored.
      t128 = '0; t128[128] = 1'b1;
      bx = t128 - 2;
      t128 = t128 - 1;
      by = t128 * t128;
      issue(bx, by, 1'b1, 1'b0, 0, 0);
      repeat (6) @(negedge clk);
      issue(5, 3, 1'b0, 1'b0, 0, 0);
      drain();
      repeat (40) @(negedge clk);

      // Reset ten cycles into a computation, with a start in the reset cycle.
      issue(319, 177, 1'b0, 1'b0, 0, 0);
      repeat (9) @(negedge clk);
      rst = 1'b1; enable_p = 1'b1; x = 5; y = 3;
      @(negedge clk);
      rst = 1'b0; enable_p = 1'b0;
      check_zero("reset_mid_run");
      d0 = done_cnt;
      repeat (80) @(negedge clk);
      checks++;
      if (done_cnt != d0) begin
         errors++;
         $display("FAIL done_after_reset: %0d pulses, required 0", done_cnt - d0);
      end
      run(319, 177, 1'b1, 91, -164);

      // Random wide operands, some sharing a power-of-two factor.
      for (int i = 0; i < 12; i++) begin
         s  = $urandom_range(0, 5);
         xi = rnd($urandom_range(1, N - 8)) << s;
         yi = rnd($urandom_range(1, N - 8)) << s;
         run(xi, yi, 1'b0, 0, 0);
      end

      // Random small operands sharing a random common factor.
      for (int i = 0; i < 8; i++) begin
         f  = $urandom_range(1, 64);
         xi = N'(f) * N'($urandom_range(0, 3000));
         yi = N'(f) * N'($urandom_range(1, 3000));
         run(xi, yi, 1'b0, 0, 0);
      end

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
